// File: rtl/reg_universal_n.sv
// General working register: parallel load, inc/dec, shift left/right, tristate bus drive, zero/carry flags.
// Build option: define REG_SAT_EN to make inc/dec saturate at the range ends instead of wrapping.
module reg_universal_n #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             inc,
    input  logic             dec,
    input  logic             shl,
    input  logic             shr,
    input  logic             ser_in,
    input  logic             enable,
    input  logic [WIDTH-1:0] Data,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_int,
    output logic             zero,
    output logic             carry
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] value_reg;
    logic [WIDTH-1:0] value_next;
    logic             carry_reg;
    logic             carry_next;
    logic             all_ones;
    logic             all_zero;

    assign all_ones = &value_reg;
    assign all_zero = ~|value_reg;

    always_comb begin
        value_next = value_reg;
        carry_next = carry_reg;
        if (load) begin
            value_next = Data;
            carry_next = 1'b0;
        end else if (inc || dec) begin
            // inc and dec together cancel and also block the shifts
            if (inc && !dec) begin
`ifdef REG_SAT_EN
                value_next = all_ones ? value_reg : value_reg + ONE;
`else
                value_next = value_reg + ONE;
`endif
                carry_next = all_ones;
            end else if (dec && !inc) begin
`ifdef REG_SAT_EN
                value_next = all_zero ? value_reg : value_reg - ONE;
`else
                value_next = value_reg - ONE;
`endif
                carry_next = all_zero;
            end
        end else if (shl) begin
            value_next = {value_reg[WIDTH-2:0], ser_in};
            carry_next = value_reg[WIDTH-1];
        end else if (shr) begin
            value_next = {ser_in, value_reg[WIDTH-1:1]};
            carry_next = value_reg[0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_reg <= RESET_VAL;
            carry_reg <= 1'b0;
        end else begin
            value_reg <= value_next;
            carry_reg <= carry_next;
        end
    end

    assign Q_int = value_reg;
    assign zero  = all_zero;
    assign carry = carry_reg;
    assign Q     = enable ? value_reg : {WIDTH{1'bz}};

endmodule
